// File: rtl/connection_block_gen2_pkg.sv
// ---------------------------------------------------------------------------
// cb_gen2_pkg
// Shared helpers for the parametrised connection block: a constant clog2 and
// the functions that place each configuration field inside the active word.
// Field layout, LSB first:
//   [input selects : NCLB*CLBIN x SELW]
//   [track selects : NT x OSELW]
//   [carry enables : NCLB*CARRY]
// ---------------------------------------------------------------------------
package cb_gen2_pkg;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   // Total track count over both sides, singles and doubles.
   function automatic int track_count(input int ws, input int wd);
      return 2 * (ws + wd);
   endfunction

   // Input selects start at bit 0.
   function automatic int in_sel_base();
      return 0;
   endfunction

   // Track-output selects follow the input selects.
   function automatic int out_sel_base(input int nclb, input int clbin, input int selw);
      return in_sel_base() + nclb * clbin * selw;
   endfunction

   // Carry enables follow the track-output selects.
   function automatic int carry_base(input int nclb, input int clbin, input int selw,
                                     input int nt, input int oselw);
      return out_sel_base(nclb, clbin, selw) + nt * oselw;
   endfunction

   // Full configuration frame length L.
   function automatic int cfg_len(input int nclb, input int clbin, input int selw,
                                  input int nt, input int oselw, input int carry);
      return carry_base(nclb, clbin, selw, nt, oselw) + nclb * carry;
   endfunction

endpackage

// File: rtl/connection_block_gen2_if.sv
// ---------------------------------------------------------------------------
// connection_block_gen2_if
// Routing-side signals of one connection-block tile.
//   tracks_in   channel track values {double1,double0,single1,single0}
//   tracks_out  channel track drive
//   clb_output  CLB outputs, CLB i at slice i
//   clb_cout    CLB carry-outs
//   carry_in    carry arriving from the neighbouring tile
//   clb_input   CLB inputs
//   clb_cin     CLB carry-ins
//   carry_out   carry leaving the tile (carry-out of the last CLB)
// Modport slave is the block's view; master is the surrounding fabric.
// ---------------------------------------------------------------------------
interface connection_block_gen2_if #(
   parameter int WS     = 4,
   parameter int WD     = 8,
   parameter int NCLB   = 2,
   parameter int CLBIN  = 10,
   parameter int CLBOUT = 5,
   parameter int CARRY  = 1
);
   localparam int NT = 2 * (WS + WD);

   logic [NT-1:0]           tracks_in;
   logic [NT-1:0]           tracks_out;
   logic [NCLB*CLBOUT-1:0]  clb_output;
   logic [NCLB*CARRY-1:0]   clb_cout;
   logic [CARRY-1:0]        carry_in;
   logic [NCLB*CLBIN-1:0]   clb_input;
   logic [NCLB*CARRY-1:0]   clb_cin;
   logic [CARRY-1:0]        carry_out;

   modport slave (
      input  tracks_in, clb_output, clb_cout, carry_in,
      output tracks_out, clb_input, clb_cin, carry_out
   );

   modport master (
      output tracks_in, clb_output, clb_cout, carry_in,
      input  tracks_out, clb_input, clb_cin, carry_out
   );

endinterface

// File: rtl/connection_block_gen2_cfg_chain.sv
// ---------------------------------------------------------------------------
// cb_cfg_chain
// Double-buffered configuration store.
//   clk       clock
//   rst       asynchronous active-low reset
//   cen       shift enable for the shadow chain
//   set_in    commit shadow to active (takes priority over cen)
//   shift_in  serial configuration in (enters at the MSB)
//   shift_out serial configuration out, shadow[0]
//   cfg_err   sticky: a commit arrived before L bits were shifted
//   active    committed configuration word
// The bit counter saturates at L, so an over-length load still commits and
// keeps only the most recent L bits.
// ---------------------------------------------------------------------------
module cb_cfg_chain
   import cb_gen2_pkg::*;
#(
   parameter int L = 198
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cen,
   input  logic         set_in,
   input  logic         shift_in,
   output logic         shift_out,
   output logic         cfg_err,
   output logic [L-1:0] active
);

   localparam int             CW   = clog2(L + 1);
   localparam logic [CW-1:0]  FULL = CW'(L);

   logic [L-1:0]  shadow_reg, shadow_next;
   logic [L-1:0]  active_reg, active_next;
   logic [CW-1:0] count_reg,  count_next;
   logic          cfg_err_reg, cfg_err_next;

   always_comb begin
      shadow_next  = shadow_reg;
      active_next  = active_reg;
      count_next   = count_reg;
      cfg_err_next = cfg_err_reg;
      if (set_in) begin
         // Every commit attempt restarts the count, accepted or not.
         count_next = '0;
         if (count_reg == FULL) begin
            active_next = shadow_reg;
         end else begin
            cfg_err_next = 1'b1;
         end
      end else if (cen) begin
         shadow_next = {shift_in, shadow_reg[L-1:1]};
         if (count_reg != FULL) begin
            count_next = count_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_reg  <= '0;
         active_reg  <= '0;
         count_reg   <= '0;
         cfg_err_reg <= 1'b0;
      end else begin
         shadow_reg  <= shadow_next;
         active_reg  <= active_next;
         count_reg   <= count_next;
         cfg_err_reg <= cfg_err_next;
      end
   end

   assign shift_out = shadow_reg[0];
   assign cfg_err   = cfg_err_reg;
   assign active    = active_reg;

endmodule

// File: rtl/connection_block_gen2.sv
// ---------------------------------------------------------------------------
// connection_block_gen2
// Connection block serving NCLB logic blocks from one routing channel, with a
// carry chain threaded through the tile and a double-buffered serial config.
//   clk        clock
//   rst        asynchronous active-low reset
//   cen        config shift enable
//   set_in     commit shadow configuration
//   shift_in   config serial in
//   shift_out  config serial out
//   cfg_err    sticky under-length commit flag
//   bus        routing signals (connection_block_gen2_if.slave)
// All routing is combinational from the active word; REG_OUT=1 adds one
// register stage on clb_input only.
// ---------------------------------------------------------------------------
module connection_block_gen2
   import cb_gen2_pkg::*;
#(
   parameter int WS      = 4,
   parameter int WD      = 8,
   parameter int NCLB    = 2,
   parameter int CLBIN   = 10,
   parameter int CLBOUT  = 5,
   parameter int CARRY   = 1,
   parameter int REG_OUT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic cen,
   input  logic set_in,
   input  logic shift_in,
   output logic shift_out,
   output logic cfg_err,
   connection_block_gen2_if.slave bus
);

   localparam int NT         = track_count(WS, WD);
   localparam int NIN        = NCLB * CLBIN;
   localparam int NOUT       = NCLB * CLBOUT;
   localparam int SELW       = clog2(NT + 1);
   localparam int OSELW      = clog2(NOUT + 1);
   localparam int IN_BASE    = in_sel_base();
   localparam int OUT_BASE   = out_sel_base(NCLB, CLBIN, SELW);
   localparam int CARRY_BASE = carry_base(NCLB, CLBIN, SELW, NT, OSELW);
   localparam int L          = cfg_len(NCLB, CLBIN, SELW, NT, OSELW, CARRY);

   logic [L-1:0]   active;
   logic [NIN-1:0] clb_input_comb;

   cb_cfg_chain #(
      .L (L)
   ) u_cfg (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen),
      .set_in    (set_in),
      .shift_in  (shift_in),
      .shift_out (shift_out),
      .cfg_err   (cfg_err),
      .active    (active)
   );

   // CLB input muxes: select 0 and selects beyond NT both give constant 0.
   for (genvar gi = 0; gi < NIN; gi++) begin : g_in
      logic [SELW-1:0] sel;
      logic            bit_val;

      assign sel = active[IN_BASE + gi*SELW +: SELW];

      always_comb begin
         bit_val = 1'b0;
         for (int k = 1; k <= NT; k++) begin
            if (sel == SELW'(k)) begin
               bit_val = bus.tracks_in[k-1];
            end
         end
      end

      assign clb_input_comb[gi] = bit_val;
   end

   // Track drivers: default is pass-through, so an unconfigured or
   // out-of-range select leaves the track untouched.
   for (genvar gi = 0; gi < NT; gi++) begin : g_trk
      logic [OSELW-1:0] sel;
      logic             bit_val;

      assign sel = active[OUT_BASE + gi*OSELW +: OSELW];

      always_comb begin
         bit_val = bus.tracks_in[gi];
         for (int k = 1; k <= NOUT; k++) begin
            if (sel == OSELW'(k)) begin
               bit_val = bus.clb_output[k-1];
            end
         end
      end

      assign bus.tracks_out[gi] = bit_val;
   end

   // Carry chain: CLB 0 takes the tile carry_in, CLB i takes CLB i-1's
   // carry-out, each gated by its enable bits.
   for (genvar gi = 0; gi < NCLB; gi++) begin : g_carry
      logic [CARRY-1:0] src;

      if (gi == 0) begin : g_first
         assign src = bus.carry_in;
      end else begin : g_chain
         assign src = bus.clb_cout[(gi-1)*CARRY +: CARRY];
      end

      assign bus.clb_cin[gi*CARRY +: CARRY] = src & active[CARRY_BASE + gi*CARRY +: CARRY];
   end

   assign bus.carry_out = bus.clb_cout[(NCLB-1)*CARRY +: CARRY];

   if (REG_OUT != 0) begin : g_reg_out
      logic [NIN-1:0] clb_input_reg;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            clb_input_reg <= '0;
         end else begin
            clb_input_reg <= clb_input_comb;
         end
      end

      assign bus.clb_input = clb_input_reg;
   end else begin : g_comb_out
      assign bus.clb_input = clb_input_comb;
   end

endmodule

// File: tb/tb_connection_block_gen2.sv
// ---------------------------------------------------------------------------
// tb_connection_block_gen2
// Drives two instances (REG_OUT=0 and REG_OUT=1) from shared stimulus and
// compares both against a frame-level reference model: a history of the most
// recent shifted bits, a since-commit shift count, and field decoding done
// with plain arithmetic on the committed frame.
// ---------------------------------------------------------------------------
module tb_connection_block_gen2;

   localparam int WS = 4, WD = 8, NCLB = 2, CLBIN = 10, CLBOUT = 5, CARRY = 1;
   localparam int NT = 24, SELW = 5, OSELW = 4, L = 198;
   localparam int NIN = 20, NOUT = 10;
   localparam int OBASE = NIN * SELW;
   localparam int CBASE = OBASE + NT * OSELW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, cen, set_in, shift_in;
   logic [NT-1:0]   tracks_in;
   logic [NOUT-1:0] clb_output;
   logic [1:0]      clb_cout;
   logic            carry_in;
   logic            shift_out, cfg_err, shift_out_r, cfg_err_r;

   connection_block_gen2_if #(.WS(WS), .WD(WD), .NCLB(NCLB), .CLBIN(CLBIN),
                              .CLBOUT(CLBOUT), .CARRY(CARRY)) bus ();
   connection_block_gen2_if #(.WS(WS), .WD(WD), .NCLB(NCLB), .CLBIN(CLBIN),
                              .CLBOUT(CLBOUT), .CARRY(CARRY)) bus_r ();

   assign bus.tracks_in    = tracks_in;
   assign bus.clb_output   = clb_output;
   assign bus.clb_cout     = clb_cout;
   assign bus.carry_in     = carry_in;
   assign bus_r.tracks_in  = tracks_in;
   assign bus_r.clb_output = clb_output;
   assign bus_r.clb_cout   = clb_cout;
   assign bus_r.carry_in   = carry_in;

   connection_block_gen2 #(.WS(WS), .WD(WD), .NCLB(NCLB), .CLBIN(CLBIN), .CLBOUT(CLBOUT),
                           .CARRY(CARRY), .REG_OUT(0)) u_dut (
      .clk(clk), .rst(rst), .cen(cen), .set_in(set_in), .shift_in(shift_in),
      .shift_out(shift_out), .cfg_err(cfg_err), .bus(bus));

   connection_block_gen2 #(.WS(WS), .WD(WD), .NCLB(NCLB), .CLBIN(CLBIN), .CLBOUT(CLBOUT),
                           .CARRY(CARRY), .REG_OUT(1)) u_dut_r (
      .clk(clk), .rst(rst), .cen(cen), .set_in(set_in), .shift_in(shift_in),
      .shift_out(shift_out_r), .cfg_err(cfg_err_r), .bus(bus_r));

   // ---------------- reference model ----------------
   bit             hist[$];      // most recent shifted bits, oldest first, at most L
   int             since;        // shifts since last commit attempt / reset
   bit [L-1:0]     m_active;
   bit             m_err;
   logic [NIN-1:0] m_reg;        // expected registered clb_input
   int errors = 0;
   int checks = 0;

   function automatic bit [L-1:0] last_frame();
      bit [L-1:0] s;
      int n;
      s = '0;
      n = hist.size();
      for (int i = 0; i < L && i < n; i++) s[L-1-i] = hist[n-1-i];
      return s;
   endfunction

   function automatic logic [NIN-1:0] f_in(bit [L-1:0] act, logic [NT-1:0] tr);
      logic [NIN-1:0] r;
      int sel;
      r = '0;
      for (int idx = 0; idx < NIN; idx++) begin
         sel = int'(act[idx*SELW +: SELW]);
         if (sel >= 1 && sel <= NT) r[idx] = tr[sel-1];
      end
      return r;
   endfunction

   function automatic logic [NT-1:0] f_tr(bit [L-1:0] act, logic [NT-1:0] tr, logic [NOUT-1:0] co);
      logic [NT-1:0] r;
      int sel;
      r = tr;
      for (int t = 0; t < NT; t++) begin
         sel = int'(act[OBASE + t*OSELW +: OSELW]);
         if (sel >= 1 && sel <= NOUT) r[t] = co[sel-1];
      end
      return r;
   endfunction

   function automatic logic [1:0] f_cin(bit [L-1:0] act, logic ci, logic [1:0] cc);
      return {cc[0] & act[CBASE+1], ci & act[CBASE]};
   endfunction

   function automatic bit [L-1:0] put_in(bit [L-1:0] f, int c, int j, int v);
      f[(c*CLBIN + j)*SELW +: SELW] = SELW'(v);
      return f;
   endfunction

   function automatic bit [L-1:0] put_tr(bit [L-1:0] f, int t, int v);
      f[OBASE + t*OSELW +: OSELW] = OSELW'(v);
      return f;
   endfunction

   function automatic bit [L-1:0] rand_frame();
      bit [L-1:0] f;
      for (int i = 0; i < L; i++) f[i] = 1'($urandom_range(0, 1));
      return f;
   endfunction

   task automatic model_reset();
      hist.delete();
      since    = 0;
      m_active = '0;
      m_err    = 1'b0;
      m_reg    = '0;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic exp_so;
      exp_so = (hist.size() == L) ? hist[0] : 1'b0;
      chk({tag, ".shift_out"},   64'(shift_out),         64'(exp_so));
      chk({tag, ".cfg_err"},     64'(cfg_err),           64'(m_err));
      chk({tag, ".clb_input"},   64'(bus.clb_input),     64'(f_in(m_active, tracks_in)));
      chk({tag, ".tracks_out"},  64'(bus.tracks_out),    64'(f_tr(m_active, tracks_in, clb_output)));
      chk({tag, ".clb_cin"},     64'(bus.clb_cin),       64'(f_cin(m_active, carry_in, clb_cout)));
      chk({tag, ".carry_out"},   64'(bus.carry_out),     64'(clb_cout[1]));
      chk({tag, ".r_clb_input"}, 64'(bus_r.clb_input),   64'(m_reg));
      chk({tag, ".r_tracks"},    64'(bus_r.tracks_out),  64'(f_tr(m_active, tracks_in, clb_output)));
      chk({tag, ".r_cfg_err"},   64'(cfg_err_r),         64'(m_err));
   endtask

   // One clock edge: update the model from the inputs presented before it.
   task automatic tick();
      m_reg = f_in(m_active, tracks_in);
      if (set_in) begin
         if (since >= L) m_active = last_frame();
         else            m_err = 1'b1;
         since = 0;
      end else if (cen) begin
         hist.push_back(shift_in);
         if (hist.size() > L) void'(hist.pop_front());
         since++;
      end
      @(posedge clk);
      #1;
   endtask

   // Shift n bits of f, f[0] first, after `extra` random leading bits.
   task automatic load(bit [L-1:0] f, int n, int extra);
      cen = 1'b1;
      set_in = 1'b0;
      for (int i = 0; i < extra + n; i++) begin
         shift_in = (i < extra) ? 1'($urandom_range(0, 1)) : f[i - extra];
         tick();
         check_all("shift");
      end
      cen = 1'b0;
   endtask

   task automatic commit(string tag);
      set_in = 1'b1;
      tick();
      set_in = 1'b0;
      check_all(tag);
      $display("%s: active committed=%0d cfg_err=%0b clb_input=%h tracks_out=%h clb_cin=%b",
               tag, (m_active == last_frame()), cfg_err, bus.clb_input, bus.tracks_out, bus.clb_cin);
   endtask

   typedef struct {
      logic [NT-1:0]   tr;
      logic [NOUT-1:0] co;
      logic [1:0]      cc;
      logic            ci;
      logic [NIN-1:0]  e_in;
      logic            e_t7;
      logic [1:0]      e_cin;
   } vec_t;

   vec_t vt[4];

   initial begin
      bit [L-1:0]    fa, fb, fc, fd, fr;
      logic [NT-1:0] e_tr;
      int            mode;

      // CLB0 input3 <- tracks_in[4]; track7 <- clb_output[5]; carry enables {1,1}
      vt[0] = '{24'h000010, 10'h000, 2'b00, 1'b1, 20'h00008, 1'b0, 2'b01};
      vt[1] = '{24'hFFFFEF, 10'h020, 2'b01, 1'b0, 20'h00000, 1'b1, 2'b10};
      vt[2] = '{24'hFFFFFF, 10'h3DF, 2'b11, 1'b1, 20'h00008, 1'b0, 2'b11};
      vt[3] = '{24'h000000, 10'h3FF, 2'b10, 1'b0, 20'h00000, 1'b1, 2'b00};

      rst = 1'b0; cen = 1'b0; set_in = 1'b0; shift_in = 1'b0;
      tracks_in = 24'hA5A5A5; clb_output = 10'h2B6; clb_cout = 2'b11; carry_in = 1'b1;
      model_reset();

      // Reset state
      #12;
      chk("rst.clb_input",  64'(bus.clb_input),  64'(0));
      chk("rst.tracks_out", 64'(bus.tracks_out), 64'(24'hA5A5A5));
      chk("rst.cfg_err",    64'(cfg_err),        64'(0));
      chk("rst.shift_out",  64'(shift_out),      64'(0));
      chk("rst.clb_cin",    64'(bus.clb_cin),    64'(0));
      check_all("rst");
      $display("reset: clb_input=%h tracks_out=%h cfg_err=%0b", bus.clb_input, bus.tracks_out, cfg_err);
      rst = 1'b1;
      tick();
      check_all("idle");

      // Frame A, exact-length load
      fa = '0;
      fa = put_in(fa, 0, 3, 5);
      fa = put_tr(fa, 7, 6);
      fa[CBASE] = 1'b1;
      fa[CBASE+1] = 1'b1;
      load(fa, L, 0);
      commit("commit_a");

      for (int v = 0; v < 4; v++) begin
         tracks_in = vt[v].tr; clb_output = vt[v].co; clb_cout = vt[v].cc; carry_in = vt[v].ci;
         #1;
         e_tr = vt[v].tr;
         e_tr[7] = vt[v].e_t7;
         chk("vec.clb_input",  64'(bus.clb_input),  64'(vt[v].e_in));
         chk("vec.tracks_out", 64'(bus.tracks_out), 64'(e_tr));
         chk("vec.clb_cin",    64'(bus.clb_cin),    64'(vt[v].e_cin));
         check_all("vec");
         $display("vec %0d: tracks_in=%h clb_output=%h clb_input=%h tracks_out=%h clb_cin=%b",
                  v, tracks_in, clb_output, bus.clb_input, bus.tracks_out, bus.clb_cin);
         tick();
      end

      // Short load (L-1 bits) is rejected; active stays frame A
      fb = '0;
      fb = put_in(fb, 1, 0, 1);
      tracks_in = 24'h000010; clb_output = 10'h3FF; clb_cout = 2'b01; carry_in = 1'b1;
      load(fb, L - 1, 0);
      chk("short.err_before", 64'(cfg_err), 64'(0));
      commit("commit_short");
      chk("short.cfg_err",    64'(cfg_err),        64'(1));
      chk("short.clb_input",  64'(bus.clb_input),  64'(20'h00008));

      // Full load of B accepted; track7 select 0 passes tracks_in[7]
      tracks_in = 24'h000081;
      load(fb, L, 0);
      commit("commit_b");
      chk("b.clb_input",  64'(bus.clb_input),  64'(20'h00400));
      chk("b.tracks_out", 64'(bus.tracks_out), 64'(24'h000081));
      chk("b.clb_cin",    64'(bus.clb_cin),    64'(0));
      chk("b.cfg_err",    64'(cfg_err),        64'(1));

      // Asynchronous reset after 100 shifts
      fc = rand_frame();
      load(fc, 100, 0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("arst.cfg_err",   64'(cfg_err),       64'(0));
      chk("arst.clb_input", 64'(bus.clb_input), 64'(0));
      chk("arst.shift_out", 64'(shift_out),     64'(0));
      check_all("arst");
      $display("async reset mid-load: cfg_err=%0b clb_input=%h", cfg_err, bus.clb_input);
      #1 rst = 1'b1;
      tick();
      // The 100 earlier shifts must not count toward this load
      load(fc, 98, 0);
      commit("commit_after_rst_short");
      chk("arst.short_err", 64'(cfg_err), 64'(1));
      load(fc, L, 0);
      commit("commit_after_rst_full");

      // cen and set_in together: commit, no shift
      fd = rand_frame();
      load(fd, L, 0);
      cen = 1'b1; shift_in = ~fd[1];
      commit("commit_with_cen");
      cen = 1'b0;
      load(rand_frame(), L, 0);

      // Randomised loads: exact, short and over-length, then random routing traffic
      for (int it = 0; it < 8; it++) begin
         fr = rand_frame();
         mode = it % 3;
         if (mode == 0)      load(fr, L, 0);
         else if (mode == 1) load(fr, $urandom_range(1, L - 1), 0);
         else                load(fr, L, $urandom_range(1, 20));
         commit("commit_rand");
         for (int c = 0; c < 6; c++) begin
            tracks_in  = NT'($urandom);
            clb_output = NOUT'($urandom);
            clb_cout   = 2'($urandom);
            carry_in   = 1'($urandom);
            #1;
            check_all("rand");
            tick();
            check_all("rand_edge");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
